bcd_digit_overlay: RTL and testbench

- Downstream consumer of the per-frame 12-bit packed-BCD value (hundreds[11:8], dozens[7:4], units[3:0]).
- Latches the value once per frame and maps the scanning pixel position to a character-ROM address.
- Turns the returned glyph row into a pixel-on flag for the on-screen menu mixer.
- Adds leading-zero blanking, invalid-digit substitution and a frame-counted blink for the selected menu field.

---
 rtl/osd_chars_pkg.sv | 19 +
 rtl/bcd_digit_coder.sv | 19 +
 rtl/bcd_digit_overlay.sv | 132 +++++++++++++
 tb/tb_bcd_digit_overlay.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/osd_chars_pkg.sv
// Character-ROM codes and field widths shared by the on-screen digit overlay.
package osd_chars_pkg;

  localparam int unsigned CHAR_CODE_W = 7;
  localparam int unsigned ROW_W       = 4;

  typedef logic [CHAR_CODE_W-1:0] char_code_t;

  localparam char_code_t CHAR_DIGIT0 = 7'h30;
  localparam char_code_t CHAR_BLANK  = 7'h20;
  localparam char_code_t CHAR_DASH   = 7'h2D;

  typedef enum logic [1:0] {
    DIG_HUNDREDS = 2'd0,
    DIG_DOZENS   = 2'd1,
    DIG_UNITS    = 2'd2
  } digit_idx_t;

endpackage

// File: rtl/bcd_digit_coder.sv
// One BCD digit to character code, with blanking and dash for non-decimal digits.
module bcd_digit_coder
  import osd_chars_pkg::*;
(
  input  logic [3:0]             digit,
  input  logic                   blank,
  output logic [CHAR_CODE_W-1:0] code
);

  always_comb begin
    code = CHAR_DIGIT0 + CHAR_CODE_W'(digit);
    if (blank) begin
      code = CHAR_BLANK;
    end else if (digit > 4'd9) begin
      code = CHAR_DASH;
    end
  end

endmodule

// File: rtl/bcd_digit_overlay.sv
// Three-digit BCD overlay: per-frame value latch, blink phase, and a glyph
// lookup pipeline turning pixel position into a pixel-on flag.
module bcd_digit_overlay
  import osd_chars_pkg::*;
#(
  parameter logic [10:0] X0           = 11'd64,
  parameter logic [10:0] Y0           = 11'd32,
  parameter int unsigned CHAR_W       = 8,
  parameter int unsigned CHAR_H       = 16,
  parameter int unsigned BLINK_FRAMES = 30,
  parameter bit          BLANK_LZ     = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        newframe,
  input  logic [11:0] bcd_value,
  input  logic        selected,
  input  logic [10:0] x,
  input  logic [10:0] y,
  input  logic        de,
  output logic [10:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic        pix_on,
  output logic        de_out
);

  localparam int unsigned COL_W = $clog2(CHAR_W);
  localparam int unsigned RW    = $clog2(CHAR_H);
  localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [10:0] X1    = X0 + 11'(3 * CHAR_W);
  localparam logic [10:0] Y1    = Y0 + 11'(CHAR_H);

  logic [11:0]      shadow;
  logic [CNT_W-1:0] blink_cnt;
  logic             phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow    <= '0;
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (newframe) begin
      shadow <= bcd_value;
      if (!selected) begin
        blink_cnt <= '0;
        phase     <= 1'b1;
      end else if (blink_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // Dozens blank only when hundreds is blanked too, so "105" keeps its zero.
  logic blank_h, blank_d;
  assign blank_h = BLANK_LZ && (shadow[11:8] == 4'd0);
  assign blank_d = blank_h && (shadow[7:4] == 4'd0);

  logic [CHAR_CODE_W-1:0] code_h, code_d, code_u;

  bcd_digit_coder u_coder_h (.digit(shadow[11:8]), .blank(blank_h), .code(code_h));
  bcd_digit_coder u_coder_d (.digit(shadow[7:4]),  .blank(blank_d), .code(code_d));
  bcd_digit_coder u_coder_u (.digit(shadow[3:0]),  .blank(1'b0),    .code(code_u));

  // Subtractions may wrap below the field origin; hit masks those cases.
  logic [10:0] dx, dy;
  logic        in_field;
  assign dx       = x - X0;
  assign dy       = y - Y0;
  assign in_field = de && (x >= X0) && (x < X1) && (y >= Y0) && (y < Y1);

  logic             hit0, hit1, hit2;
  logic             de0, de1, de2;
  digit_idx_t       idx0;
  logic [COL_W-1:0] col0, col1, col2;
  logic [ROW_W-1:0] row0;

  logic [CHAR_CODE_W-1:0] code_sel;
  always_comb begin
    code_sel = code_u;
    case (idx0)
      DIG_HUNDREDS: code_sel = code_h;
      DIG_DOZENS:   code_sel = code_d;
      default:      code_sel = code_u;
    endcase
  end

  logic [COL_W-1:0] bit_sel;
  assign bit_sel = COL_W'(CHAR_W - 1) - col2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit0     <= 1'b0;
      de0      <= 1'b0;
      idx0     <= DIG_HUNDREDS;
      col0     <= '0;
      row0     <= '0;
      hit1     <= 1'b0;
      de1      <= 1'b0;
      col1     <= '0;
      rom_addr <= '0;
      hit2     <= 1'b0;
      de2      <= 1'b0;
      col2     <= '0;
      pix_on   <= 1'b0;
      de_out   <= 1'b0;
    end else begin
      hit0 <= in_field;
      de0  <= de;
      idx0 <= digit_idx_t'(2'(dx >> COL_W));
      col0 <= dx[COL_W-1:0];
      row0 <= ROW_W'(dy[RW-1:0]);

      if (hit0) begin
        rom_addr <= {code_sel, row0};
      end
      hit1 <= hit0;
      de1  <= de0;
      col1 <= col0;

      hit2 <= hit1;
      de2  <= de1;
      col2 <= col1;

      pix_on <= hit2 & phase & rom_data[bit_sel];
      de_out <= de2;
    end
  end

endmodule

// File: tb/tb_bcd_digit_overlay.sv
// Bench for bcd_digit_overlay: character ROM model plus an arithmetic model of
// the digit field, compared step by step against pix_on, de_out and rom_addr.
module tb_bcd_digit_overlay;

  localparam int X0 = 64;
  localparam int Y0 = 32;
  localparam int CW = 8;
  localparam int CH = 16;
  localparam int BF = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        newframe = 1'b0;
  logic [11:0] bcd_value = '0;
  logic        selected = 1'b0;
  logic [10:0] x = '0;
  logic [10:0] y = '0;
  logic        de = 1'b0;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data;
  logic        pix_on;
  logic        de_out;
  logic        rom_ff = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_digit_overlay #(
    .X0(11'd64), .Y0(11'd32), .CHAR_W(8), .CHAR_H(16),
    .BLINK_FRAMES(2), .BLANK_LZ(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .newframe(newframe), .bcd_value(bcd_value),
    .selected(selected), .x(x), .y(y), .de(de), .rom_addr(rom_addr),
    .rom_data(rom_data), .pix_on(pix_on), .de_out(de_out)
  );

  function automatic logic [7:0] glyph(input logic [10:0] a);
    int v;
    logic [7:0] g;
    v = int'(a);
    g = 8'((v * 37) ^ (v >> 2));
    return g;
  endfunction

  always @(posedge clk) rom_data <= rom_ff ? 8'hFF : glyph(rom_addr);

  // Model state
  int m_shadow = 0;
  int m_cnt    = 0;
  bit m_phase  = 1'b1;

  typedef struct { logic pix; logic de; } pexp_t;
  typedef struct { bit v; logic [10:0] a; } aexp_t;
  pexp_t pq[$];
  aexp_t aq[$];

  function automatic int code_of(int idx);
    int h, t, u, d;
    h = (m_shadow >> 8) & 15;
    t = (m_shadow >> 4) & 15;
    u = m_shadow & 15;
    d = (idx == 0) ? h : (idx == 1) ? t : u;
    if (idx == 0 && h == 0) return 'h20;
    if (idx == 1 && h == 0 && t == 0) return 'h20;
    if (d > 9) return 'h2D;
    return 'h30 + d;
  endfunction

  task automatic step(input int xi, input int yi, input bit dei, input bit nfi);
    pexp_t pe;
    aexp_t ae;
    bit    hit;
    int    idx, col, row, addr;
    logic [7:0] g;
    @(negedge clk);
    if (pq.size() == 4) begin
      pe = pq.pop_front();
      checks++;
      assert (pix_on === pe.pix) else begin
        errors++;
        $error("FAIL pix_on at x=%0d y=%0d got %0b exp %0b", x, y, pix_on, pe.pix);
      end
      checks++;
      assert (de_out === pe.de) else begin
        errors++;
        $error("FAIL de_out got %0b exp %0b", de_out, pe.de);
      end
    end
    if (aq.size() == 2) begin
      ae = aq.pop_front();
      if (ae.v) begin
        checks++;
        assert (rom_addr === ae.a) else begin
          errors++;
          $error("FAIL rom_addr got %03h exp %03h", rom_addr, ae.a);
        end
      end
    end
    x = 11'(xi);
    y = 11'(yi);
    de = dei;
    newframe = nfi;
    if (nfi) begin
      m_shadow = int'(bcd_value);
      if (!selected) begin
        m_cnt = 0;
        m_phase = 1'b1;
      end else if (m_cnt == BF - 1) begin
        m_cnt = 0;
        m_phase = !m_phase;
      end else begin
        m_cnt++;
      end
    end
    hit = dei && xi >= X0 && xi < X0 + 3 * CW && yi >= Y0 && yi < Y0 + CH;
    pe.pix = 1'b0;
    pe.de = dei;
    ae.v = hit;
    ae.a = '0;
    if (hit) begin
      idx = (xi - X0) / CW;
      col = (xi - X0) % CW;
      row = (yi - Y0) % CH;
      addr = code_of(idx) * 16 + row;
      ae.a = 11'(addr);
      g = rom_ff ? 8'hFF : glyph(11'(addr));
      pe.pix = m_phase & g[CW - 1 - col];
    end
    pq.push_back(pe);
    aq.push_back(ae);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1'b0, 1'b0);
  endtask

  task automatic new_frame();
    idle(4);
    step(0, 0, 1'b0, 1'b1);
    idle(4);
  endtask

  task automatic scan(input int ylo, input int yhi, input int xlo, input int xhi);
    for (int yy = ylo; yy <= yhi; yy++) begin
      for (int xx = xlo; xx <= xhi; xx++) step(xx, yy, 1'b1, 1'b0);
      step(0, yy, 1'b0, 1'b0);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    checks++;
    assert (pix_on === 1'b0) else begin errors++; $error("FAIL reset pix_on got %0b exp 0", pix_on); end
    checks++;
    assert (de_out === 1'b0) else begin errors++; $error("FAIL reset de_out got %0b exp 0", de_out); end
    checks++;
    assert (rom_addr === 11'd0) else begin errors++; $error("FAIL reset rom_addr got %03h exp 000", rom_addr); end
    rst_n = 1'b1;

    // Directed values: kept zero, all-blank leading, invalid dozens
    bcd_value = 12'h105; new_frame(); scan(Y0 - 1, Y0 + CH, X0 - 2, X0 + 3 * CW + 1);
    bcd_value = 12'h007; new_frame(); scan(Y0, Y0 + CH - 1, X0, X0 + 3 * CW - 1);
    bcd_value = 12'h0A3; new_frame(); scan(Y0, Y0 + CH - 1, X0, X0 + 3 * CW - 1);

    // Mid-frame change of the input must not reach the display until newframe
    bcd_value = 12'h123; new_frame(); scan(Y0, Y0 + 7, X0, X0 + 3 * CW - 1);
    bcd_value = 12'h456; scan(Y0 + 8, Y0 + CH - 1, X0, X0 + 3 * CW - 1);
    new_frame(); scan(Y0, Y0 + 3, X0, X0 + 3 * CW - 1);

    // Random values and scattered pixels
    for (int f = 0; f < 6; f++) begin
      bcd_value = 12'($urandom);
      new_frame();
      for (int i = 0; i < 150; i++)
        step(X0 - 4 + int'($urandom_range(0, 31)), Y0 - 2 + int'($urandom_range(0, 19)),
             1'($urandom_range(0, 1)), 1'b0);
    end

    // Blink with all-ones glyphs so suppression is visible on every pixel
    idle(4);
    rom_ff = 1'b1;
    bcd_value = 12'h888;
    selected = 1'b1;
    for (int f = 0; f < 6; f++) begin
      new_frame();
      scan(Y0 + 3, Y0 + 3, X0 - 1, X0 + 3 * CW);
    end
    selected = 1'b0;
    new_frame(); scan(Y0 + 3, Y0 + 3, X0 - 1, X0 + 3 * CW);

    // Field edges
    new_frame();
    step(X0 - 1, Y0 + 8, 1'b1, 1'b0);
    step(X0, Y0 + 8, 1'b1, 1'b0);
    step(X0 + 23, Y0 + 8, 1'b1, 1'b0);
    step(X0 + 24, Y0 + 8, 1'b1, 1'b0);
    step(X0 + 6, Y0 + 15, 1'b1, 1'b0);
    step(X0 + 6, Y0 + 16, 1'b1, 1'b0);
    step(X0 + 6, Y0 - 1, 1'b1, 1'b0);
    step(X0 + 6, Y0 + 8, 1'b0, 1'b0);
    idle(4);
    rom_ff = 1'b0;

    // Reset in the middle of a line
    bcd_value = 12'h987; new_frame();
    for (int xx = X0; xx < X0 + 12; xx++) step(xx, Y0 + 1, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    de = 1'b0;
    #1;
    checks++;
    assert (pix_on === 1'b0) else begin errors++; $error("FAIL midrst pix_on got %0b exp 0", pix_on); end
    checks++;
    assert (de_out === 1'b0) else begin errors++; $error("FAIL midrst de_out got %0b exp 0", de_out); end
    checks++;
    assert (rom_addr === 11'd0) else begin errors++; $error("FAIL midrst rom_addr got %03h exp 000", rom_addr); end
    pq.delete();
    aq.delete();
    m_shadow = 0;
    m_cnt = 0;
    m_phase = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    scan(Y0, Y0 + CH - 1, X0, X0 + 3 * CW - 1);
    idle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
